shift_add_multiplier_32: RTL



---
 rtl/shift_add_multiplier_32.sv | 122 ++++++++++++
 1 files changed

// File: rtl/shift_add_multiplier_32.sv
// Radix-2 shift-add unsigned 32x32->64 multiplier with a start/busy/done handshake.
// One 32-bit tree-carry adder does one partial-product addition per cycle.

module fulladder_with_tree_carry_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        carry_in,
    output logic [31:0] sum,
    output logic        carry_out
);

    logic [31:0] prop;
    logic [31:0] grp_g;
    logic [31:0] grp_p;
    logic [31:0] nxt_g;
    logic [31:0] nxt_p;

    // Kogge-Stone prefix tree; carry_in is folded into bit 0's generate.
    always_comb begin
        prop     = a ^ b;
        grp_g    = a & b;
        grp_p    = prop;
        grp_g[0] = grp_g[0] | (prop[0] & carry_in);
        nxt_g    = grp_g;
        nxt_p    = grp_p;
        for (int d = 1; d < 32; d = d * 2) begin
            nxt_g = grp_g;
            nxt_p = grp_p;
            for (int i = d; i < 32; i++) begin
                nxt_g[i] = grp_g[i] | (grp_p[i] & grp_g[i-d]);
                nxt_p[i] = grp_p[i] & grp_p[i-d];
            end
            grp_g = nxt_g;
            grp_p = nxt_p;
        end
        sum       = prop ^ {grp_g[30:0], carry_in};
        carry_out = grp_g[31];
    end

endmodule

module shift_add_multiplier_32 #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] mcand;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

    assign addend  = acc_lo[0] ? mcand : '0;
    assign product = {acc_hi, acc_lo};

    fulladder_with_tree_carry_32 u_adder (
        .a         (acc_hi),
        .b         (addend),
        .carry_in  (1'b0),
        .sum       (sum),
        .carry_out (carry_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= StIdle;
            acc_hi <= '0;
            acc_lo <= '0;
            mcand  <= '0;
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        mcand  <= multiplicand;
                        acc_lo <= multiplier;
                        acc_hi <= '0;
                        count  <= '0;
                        state  <= StRun;
                        busy   <= 1'b1;
                    end
                end
                StRun: begin
                    // Consumed multiplier bits leave acc_lo as product bits enter from the top.
                    {acc_hi, acc_lo} <= {carry_out, sum, acc_lo[WIDTH-1:1]};
                    count            <= count + CNT_W'(1);
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state <= StDone;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                StDone: begin
                    state <= StIdle;
                    done  <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
